// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch stage with a decoupled request/response memory
// port, an in-flight PC queue for outstanding requests and a DEPTH-entry
// prefetch FIFO toward decode. Redirects flush the FIFO and drop late responses.
// Optional feature macro: IF_PERF_EN builds the fetch/flush performance counters;
// without it both perf ports read zero and no counter flops exist.
module if_prefetch #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_d_o,
  input  logic            ready_d_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] inst_d_o,
  output logic [XLEN-1:0] pc4_d_o,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_flush_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] fifo_pc_mem   [DEPTH];
  logic [XLEN-1:0] fifo_inst_mem [DEPTH];
  logic [AW-1:0]   fifo_wr_reg, fifo_rd_reg;
  logic [CW-1:0]   fifo_cnt_reg;
  logic [XLEN-1:0] infl_mem [MAX_OUTST];
  logic [IW-1:0]   infl_wr_reg, infl_rd_reg;
  logic [OW-1:0]   outst_reg, outst_next;
  logic [OW-1:0]   drop_reg, drop_next;

  logic fifo_valid, credit_ok, issue, resp, resp_drop, resp_take, fifo_pop;

  // In-flight queue depth need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] infl_inc(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUTST - 1)) ? '0 : p + IW'(1);
  endfunction

  // Credit rule: every granted request is guaranteed a FIFO slot on return.
  always_comb begin
    fifo_valid = (fifo_cnt_reg != '0);
    credit_ok  = (outst_reg < OW'(MAX_OUTST)) &&
                 ((32'(fifo_cnt_reg) + 32'(outst_reg)) < DEPTH);
    imem_req_o = rst_ni && !redirect_i && credit_ok;
    issue      = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp       = imem_rvalid_i && (outst_reg != '0);
    resp_drop  = resp && (redirect_i || (drop_reg != '0));
    resp_take  = resp && !redirect_i && (drop_reg == '0);
    fifo_pop   = fifo_valid && ready_d_i;
  end

  // Outstanding and drop bookkeeping; a redirect turns everything still in flight into drops.
  always_comb begin
    outst_next = outst_reg;
    if (issue && !resp)
      outst_next = outst_reg + OW'(1);
    else if (!issue && resp)
      outst_next = outst_reg - OW'(1);
    drop_next = drop_reg;
    if (redirect_i)
      drop_next = outst_next;
    else if (resp_drop)
      drop_next = drop_reg - OW'(1);
  end

  // Decode head is combinational from the FIFO and forced to zero when empty.
  always_comb begin
    valid_d_o = fifo_valid;
    pc_d_o    = fifo_valid ? fifo_pc_mem[fifo_rd_reg]   : '0;
    inst_d_o  = fifo_valid ? fifo_inst_mem[fifo_rd_reg] : '0;
    pc4_d_o   = fifo_valid ? pc_d_o + XLEN'(4)          : '0;
  end

  assign imem_addr_o = pc_reg;

  // Control state: fetch PC, FIFO pointers, in-flight pointers, outstanding and drop counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_reg       <= RESET_PC;
      fifo_wr_reg  <= '0;
      fifo_rd_reg  <= '0;
      fifo_cnt_reg <= '0;
      infl_wr_reg  <= '0;
      infl_rd_reg  <= '0;
      outst_reg    <= '0;
      drop_reg     <= '0;
    end else begin
      outst_reg <= outst_next;
      drop_reg  <= drop_next;
      if (redirect_i) begin
        pc_reg       <= redirect_pc_i;
        fifo_wr_reg  <= '0;
        fifo_rd_reg  <= '0;
        fifo_cnt_reg <= '0;
        infl_wr_reg  <= '0;
        infl_rd_reg  <= '0;
      end else begin
        if (issue) begin
          pc_reg      <= pc_reg + XLEN'(4);
          infl_wr_reg <= infl_inc(infl_wr_reg);
        end
        if (resp_take) begin
          infl_rd_reg <= infl_inc(infl_rd_reg);
          fifo_wr_reg <= fifo_wr_reg + AW'(1);
        end
        if (fifo_pop)
          fifo_rd_reg <= fifo_rd_reg + AW'(1);
        case ({resp_take, fifo_pop})
          2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
          2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
          default: fifo_cnt_reg <= fifo_cnt_reg;
        endcase
      end
    end
  end

  // Storage arrays: issued PCs wait in infl_mem, accepted responses land in the FIFO.
  always_ff @(posedge clk_i) begin
    if (issue)
      infl_mem[infl_wr_reg] <= pc_reg;
    if (resp_take) begin
      fifo_pc_mem[fifo_wr_reg]   <= infl_mem[infl_rd_reg];
      fifo_inst_mem[fifo_wr_reg] <= imem_rdata_i;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_reg, perf_flush_reg, flush_add;

  // Flushed work: dropped responses plus FIFO entries discarded by a redirect.
  always_comb begin
    flush_add = 32'(resp_drop);
    if (redirect_i)
      flush_add = flush_add + 32'(fifo_cnt_reg) - 32'(fifo_pop);
  end

  // Performance counters, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_fetch_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      perf_fetch_reg <= perf_fetch_reg + 32'(fifo_pop);
      perf_flush_reg <= perf_flush_reg + flush_add;
    end
  end

  assign perf_fetch_o = perf_fetch_reg;
  assign perf_flush_o = perf_flush_reg;
`else
  assign perf_fetch_o = '0;
  assign perf_flush_o = '0;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: table-driven start-up/back-pressure/stall vectors, hand-written
// redirect and wrap sequences, then randomized traffic checked every cycle against
// a queue-based reference model of the fetch stage and a latency-modelled memory.
module tb_if_prefetch;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        valid_d_o;
  logic        ready_d_i = 1'b0;
  logic [31:0] pc_d_o, inst_d_o, pc4_d_o;
  logic [31:0] perf_fetch_o, perf_flush_o;

  always #5 clk_i = ~clk_i;

  if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .valid_d_o(valid_d_o),
    .ready_d_i(ready_d_i), .pc_d_o(pc_d_o), .inst_d_o(inst_d_o), .pc4_d_o(pc4_d_o),
    .perf_fetch_o(perf_fetch_o), .perf_flush_o(perf_flush_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: outstanding requests in issue order (keep=0 once a redirect
  // has made them stale), FIFO contents, fetch PC and counters.
  typedef struct { logic [31:0] pc; bit keep; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { int due; logic [31:0] addr; } mem_t;
  infl_t       m_outq[$];
  ent_t        m_fifo[$];
  mem_t        mem_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_perf_fetch, m_perf_flush;
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] popped_pc[$];
  logic [31:0] popped_pc4[$];

  typedef struct {
    bit gnt; bit ready; bit req; logic [31:0] addr; bit valid; logic [31:0] pc;
  } vec_t;
  vec_t tbl[24];
  vec_t no_vec;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, got no event expected one (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_outq.delete();
    m_fifo.delete();
    mem_q.delete();
    m_pc = 32'h0;
    m_perf_fetch = '0;
    m_perf_flush = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"},   32'(imem_req_o), 32'h0);
    check({tag, " addr"},  imem_addr_o, 32'h0);
    check({tag, " valid"}, 32'(valid_d_o), 32'h0);
    check({tag, " pc"},    pc_d_o, 32'h0);
    check({tag, " inst"},  inst_d_o, 32'h0);
    check({tag, " pc4"},   pc4_d_o, 32'h0);
    check({tag, " pfetch"}, perf_fetch_o, 32'h0);
    check({tag, " pflush"}, perf_flush_o, 32'h0);
  endtask

  // One clock cycle, entered and left at a falling edge. Drives inputs, compares
  // outputs against the model (and optionally a table row), then advances the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit gnt, input bit ready,
                       input bit stall, input bit spurious, input bit use_vec, input int idx,
                       input vec_t v);
    bit          rv, req, pop, resp, ev;
    logic [31:0] rd, epc, einst, epc4;
    infl_t       e;
    rv = 1'b0;
    rd = $urandom;
    if (!stall && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = inst_of(mem_q[0].addr);
    end else if (spurious && mem_q.size() == 0) begin
      rv = 1'b1;
    end
    redirect_i = redir; redirect_pc_i = rpc; imem_gnt_i = gnt; ready_d_i = ready;
    imem_rvalid_i = rv; imem_rdata_i = rd;
    #1;
    req = rst_ni && !redir && (m_outq.size() < MAX_OUTST) &&
          (m_fifo.size() + m_outq.size() < DEPTH);
    ev = (m_fifo.size() > 0);
    epc   = ev ? m_fifo[0].pc : 32'h0;
    einst = ev ? m_fifo[0].inst : 32'h0;
    epc4  = ev ? epc + 32'h4 : 32'h0;
    check("req", 32'(imem_req_o), 32'(req));
    check("addr", imem_addr_o, m_pc);
    check("valid", 32'(valid_d_o), 32'(ev));
    check("pc_d", pc_d_o, epc);
    check("inst_d", inst_d_o, einst);
    check("pc4_d", pc4_d_o, epc4);
`ifdef IF_PERF_EN
    check("perf_fetch", perf_fetch_o, m_perf_fetch);
    check("perf_flush", perf_flush_o, m_perf_flush);
`else
    check("perf_fetch", perf_fetch_o, 32'h0);
    check("perf_flush", perf_flush_o, 32'h0);
`endif
    if (use_vec) begin
      check($sformatf("vec%0d req", idx), 32'(imem_req_o), 32'(v.req));
      check($sformatf("vec%0d addr", idx), imem_addr_o, v.addr);
      check($sformatf("vec%0d valid", idx), 32'(valid_d_o), 32'(v.valid));
      check($sformatf("vec%0d pc", idx), pc_d_o, v.valid ? v.pc : 32'h0);
      check($sformatf("vec%0d inst", idx), inst_d_o, v.valid ? inst_of(v.pc) : 32'h0);
      check($sformatf("vec%0d pc4", idx), pc4_d_o, v.valid ? v.pc + 32'h4 : 32'h0);
    end
    if (valid_d_o && ready) begin
      popped_pc.push_back(pc_d_o);
      popped_pc4.push_back(pc4_d_o);
      $display("decode pc=%h inst=%h pc4=%h", pc_d_o, inst_d_o, pc4_d_o);
    end
    // Advance the model for the coming rising edge.
    pop  = ev && ready;
    resp = rv && (m_outq.size() > 0);
    if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
    if (pop) begin
      void'(m_fifo.pop_front());
      m_perf_fetch++;
    end
    if (redir) begin
      m_perf_flush += 32'(m_fifo.size()) + 32'(resp);
      m_fifo.delete();
      if (resp) void'(m_outq.pop_front());
      foreach (m_outq[i]) m_outq[i].keep = 1'b0;
      m_pc = rpc;
    end else begin
      if (resp) begin
        e = m_outq.pop_front();
        if (e.keep) m_fifo.push_back('{pc: e.pc, inst: rd});
        else m_perf_flush++;
      end
      if (req && gnt) begin
        m_outq.push_back('{pc: m_pc, keep: 1'b1});
        mem_q.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)), addr: m_pc});
        m_pc = m_pc + 32'h4;
      end
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit gnt, input bit ready,
                      input bit stall, input bit spurious);
    cycle(redir, rpc, gnt, ready, stall, spurious, 1'b0, 0, no_vec);
  endtask

  task automatic wait_pops(input int want, input string name);
    int k = 0;
    while (popped_pc.size() < want && k < 40) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      k++;
    end
    if (popped_pc.size() < want) timeout(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    logic [31:0] r, rpc;
    bit redir;
    no_vec = '{gnt: 1'b0, ready: 1'b0, req: 1'b0, addr: 32'h0, valid: 1'b0, pc: 32'h0};
    // {gnt, ready, exp req, exp addr, exp valid, exp head pc}; memory latency is 1.
    tbl = '{
      '{1,1,1,32'h00,0,32'h00}, '{1,1,1,32'h04,0,32'h00}, '{1,1,1,32'h08,1,32'h00},
      '{1,1,1,32'h0C,1,32'h04}, '{1,1,1,32'h10,1,32'h08}, '{1,0,1,32'h14,1,32'h0C},
      '{1,0,1,32'h18,1,32'h0C}, '{1,0,0,32'h1C,1,32'h0C}, '{1,0,0,32'h1C,1,32'h0C},
      '{1,0,0,32'h1C,1,32'h0C}, '{1,1,0,32'h1C,1,32'h0C}, '{1,1,1,32'h1C,1,32'h10},
      '{1,1,1,32'h20,1,32'h14}, '{1,1,1,32'h24,1,32'h18}, '{1,1,1,32'h28,1,32'h1C},
      '{1,1,1,32'h2C,1,32'h20}, '{0,1,1,32'h30,1,32'h24}, '{0,1,1,32'h30,1,32'h28},
      '{0,1,1,32'h30,1,32'h2C}, '{0,1,1,32'h30,0,32'h00}, '{0,1,1,32'h30,0,32'h00},
      '{1,1,1,32'h30,0,32'h00}, '{1,1,1,32'h34,0,32'h00}, '{1,1,1,32'h38,1,32'h30}
    };
    model_reset();
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;

    // Start-up, back-pressure to a full FIFO, release, then a 5-cycle grant stall.
    for (int i = 0; i < 24; i++)
      cycle(1'b0, 32'h0, tbl[i].gnt, tbl[i].ready, 1'b0, 1'b0, 1'b1, i, tbl[i]);

    // Redirect to 0x100 while two requests are outstanding.
    lat_min = 3; lat_max = 3;
    k = 0;
    while (m_outq.size() != MAX_OUTST && k < 20) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      k++;
    end
    if (m_outq.size() != MAX_OUTST) timeout("redirect_setup");
    base = popped_pc.size();
    step(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_pops(base + 1, "redirect_first_pop");
    if (popped_pc.size() > base) check("redirect first pc", popped_pc[base], 32'h100);

    // Drain, then a two-cycle redirect: 0x200 followed by 0x300.
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    base = popped_pc.size();
    step(1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
    redirect_i = 1'b0; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
    #1;
    check("post-redirect req", 32'(imem_req_o), 32'h1);
    check("post-redirect addr", imem_addr_o, 32'h300);
    wait_pops(base + 1, "double_redirect_pop");
    if (popped_pc.size() > base) check("double redirect first pc", popped_pc[base], 32'h300);

    // Address wrap at the top of the 32-bit space.
    repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    base = popped_pc.size();
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_pops(base + 3, "wrap_pops");
    if (popped_pc.size() >= base + 3) begin
      check("wrap pc0", popped_pc[base], 32'hFFFF_FFF8);
      check("wrap pc1", popped_pc[base + 1], 32'hFFFF_FFFC);
      check("wrap pc1 pc4", popped_pc4[base + 1], 32'h0);
      check("wrap pc2", popped_pc[base + 2], 32'h0);
    end

    // Randomized traffic with variable latency, stalls, redirects and stray rvalid.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      redir = ($urandom_range(99, 0) < 3);
      r = $urandom;
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | (r & 32'hC)) : (r & ~32'h3);
      step(redir, rpc, ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7),
           ($urandom_range(9, 0) == 0), ($urandom_range(19, 0) == 0));
    end

    // Asynchronous reset asserted between clock edges must act immediately.
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 40; i++)
      step(1'b0, 32'h0, ($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 7), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised instruction-fetch stage with a decoupled memory request/response interface and a DEPTH-entry prefetch FIFO between fetch and decode.
- Successor to the single-register fetch stage: XLEN-generic, configurable reset vector, multiple outstanding requests, valid/ready decode handshake, and redirect-flush that discards in-flight responses.
- Sits between the PC-redirect source (EX branch/jump resolution) and the ID stage.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).
- MAX_OUTST, 2, maximum outstanding memory requests (1..DEPTH).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- redirect_i  in  1  redirect/flush request (branch taken, jump).
- redirect_pc_i  in  XLEN  new fetch PC, sampled when redirect_i=1.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  XLEN  fetch address (current fetch PC).
- imem_gnt_i  in  1  memory accepts request this cycle (req&gnt = issued).
- imem_rvalid_i  in  1  response valid, in-order, >=1 cycle after grant.
- imem_rdata_i  in  XLEN  response instruction.
- valid_d_o  out  1  FIFO head valid toward decode.
- ready_d_i  in  1  decode accepts head (valid&ready = pop).
- pc_d_o  out  XLEN  PC of head instruction.
- inst_d_o  out  XLEN  head instruction.
- pc4_d_o  out  XLEN  pc_d_o + 4, modulo 2^XLEN.
- perf_fetch_o  out  32  retired-to-decode counter (see Optional Feature).
- perf_flush_o  out  32  discarded-response counter (see Optional Feature).

Behaviour:
- Reset (async, rst_ni=0): fetch PC=RESET_PC, FIFO empty, outstanding=0, drop count=0, imem_req_o=0, valid_d_o=0, pc_d_o/inst_d_o/pc4_d_o=0, perf counters=0.
- Credit rule: imem_req_o=1 iff !redirect_i && outstanding<MAX_OUTST && (fifo_count+outstanding)<DEPTH. A granted response therefore always has a FIFO slot.
- Issue: on req&gnt, an entry {addr} is pushed to an internal in-flight PC queue (depth MAX_OUTST), fetch PC += 4 (wraps mod 2^XLEN), outstanding+1.
- Response: on rvalid with drop count=0, pop in-flight PC and push {pc, rdata} into FIFO. Same-cycle grant and response keep outstanding unchanged.
- Decode: valid_d_o = FIFO non-empty; head fields are combinational from the FIFO head and are 0 when empty. Pop on valid_d_o&ready_d_i. Push and pop in the same cycle when full: the credit rule forbids this; when empty, the entry is visible the cycle after the push (1-cycle response-to-decode latency).
- Redirect (redirect_i=1): in the same edge, FIFO cleared, in-flight PC queue cleared, drop count=outstanding (minus 1 if rvalid this cycle), outstanding tracks the same, fetch PC=redirect_pc_i. No request is issued in the redirect cycle. The first request at the new PC is issued the next cycle.
- Drop: while drop count>0, each rvalid is discarded and decrements drop count and outstanding. New requests may issue during draining; their responses are accepted only after drop count reaches 0 (in-order guarantee).
- Back-to-back redirects: the last one wins. Drop count accumulates all still-outstanding requests.
- rvalid with outstanding=0: protocol error. It is ignored and state is unchanged.

Optional Feature:
- IF_PERF_EN defined: perf_fetch_o increments on each decode pop. perf_flush_o increments on each dropped response plus each FIFO entry cleared by redirect (count added in one cycle). Both wrap at 2^32.
- Not defined: both ports tied to 0, no counter flops.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle rvalid, ready_d_i=1 -> decode sees PCs 0x0,0x4,0x8,... in order. pc4_d_o=pc+4. First valid_d_o appears 3 cycles after reset release.
- ready_d_i=0 with DEPTH=4, MAX_OUTST=2 -> exactly 4 entries buffered. imem_req_o drops once fifo+outstanding=4 and stays 0. On ready re-assertion, no instruction is lost or duplicated.
- Redirect to 0x100 with 2 responses outstanding -> both late responses dropped. The next decode PC is 0x100, and perf_flush_o counts the drops plus the flushed entries (IF_PERF_EN).
- redirect_i held 2 cycles (0x200 then 0x300) -> the first fetched and decoded PC is 0x300, with no 0x200 instruction delivered.
- imem_gnt_i=0 for 5 cycles -> imem_req_o and imem_addr_o held stable and the PC does not advance.
- Fetch PC 0xFFFFFFFC (XLEN=32) -> next request address wraps to 0x0, and pc4_d_o for that instruction is 0x0.
